// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit:
// FSM states, word/iteration sizes, exception causes and small helpers.
package mult_div_pkg;

  localparam int WORD  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Why a completed operation raised data_exception.
  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MULT_OVF = 2'd1;
  localparam logic [1:0] EXC_DIV_ZERO = 2'd2;
  localparam logic [1:0] EXC_DIV_OVF  = 2'd3;

  // Two's complement negation of a word.
  function automatic logic [WORD-1:0] negate(input logic [WORD-1:0] v);
    return (~v) + {{(WORD-1){1'b0}}, 1'b1};
  endfunction

  // Unsigned magnitude of a signed word; 0x80000000 maps to 2^31.
  function automatic logic [WORD-1:0] magnitude(input logic [WORD-1:0] v);
    return v[WORD-1] ? negate(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step
  import mult_div_pkg::*;
(
  input  logic [WORD-1:0] rem_in,
  input  logic [WORD-1:0] quo_in,
  input  logic [WORD-1:0] divisor,
  output logic [WORD-1:0] rem_out,
  output logic [WORD-1:0] quo_out
);

  logic [WORD:0]   shifted;
  logic [WORD+1:0] diff;
  logic            qbit;

  // Trial subtraction; a borrow out of the top bit means restore.
  always_comb begin
    shifted = {rem_in, quo_in[WORD-1]};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    qbit    = ~diff[WORD+1];
    rem_out = qbit ? diff[WORD-1:0] : shifted[WORD-1:0];
    quo_out = {quo_in[WORD-2:0], qbit};
  end

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring on
// magnitudes). Each operation takes a fixed 33 cycles from start to result.
//
// Handshake: ctrl_MULT/ctrl_DIV are single-cycle start pulses sampled
// together with the operands on the rising edge; a start in any state
// abandons whatever was in flight. data_resultRDY is high for exactly one
// cycle (state DONE) and data_result/data_exception are valid from then on,
// holding until the next completion. There is no back-pressure.
module mult_div
  import mult_div_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [WORD-1:0] data_operandA,
  input  logic [WORD-1:0] data_operandB,
  input  logic            ctrl_MULT,
  input  logic            ctrl_DIV,
  output logic [WORD-1:0] data_result,
  output logic            data_exception,
  output logic            data_resultRDY,
  output logic [1:0]      dbg_state
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic              fin_q;        // all ITERS iterations done, result next edge
  logic [2*WORD:0]   acc_q;        // MULT: {A, Q, q-1}; DIV: {0, rem, quo}
  logic [WORD-1:0]   opb_q;        // MULT: multiplicand; DIV: divisor magnitude
  logic              neg_q;        // DIV: operand signs differ
  logic              dbz_q;        // DIV: divisor is zero

  logic              start;
  logic              busy;
  logic [WORD:0]     booth_hi;
  logic [WORD:0]     booth_m;
  logic [WORD:0]     booth_sum;
  logic [2*WORD:0]   booth_next;
  logic [WORD-1:0]   div_rem;
  logic [WORD-1:0]   div_quo;
  logic [2*WORD:0]   step_next;
  logic [WORD-1:0]   fin_result;
  logic [1:0]        fin_cause;

  assign start          = ctrl_MULT | ctrl_DIV;
  assign busy           = (state_q == S_MULT) || (state_q == S_DIV);
  assign data_resultRDY = (state_q == S_DONE);
  assign dbg_state      = state_q;

  div_step u_div_step (
    .rem_in  (acc_q[2*WORD-1:WORD]),
    .quo_in  (acc_q[WORD-1:0]),
    .divisor (opb_q),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  // Booth step: add/subtract the multiplicand in 33 bits, then shift right.
  // The 33rd sum bit is absorbed by the shift, so a 0x80000000 multiplicand
  // never overflows the 32-bit upper half.
  always_comb begin
    booth_hi = {acc_q[2*WORD], acc_q[2*WORD:WORD+1]};
    booth_m  = {opb_q[WORD-1], opb_q};
    unique case (acc_q[1:0])
      2'b01:   booth_sum = booth_hi + booth_m;
      2'b10:   booth_sum = booth_hi - booth_m;
      default: booth_sum = booth_hi;
    endcase
    booth_next = {booth_sum, acc_q[WORD:1]};
  end

  // Select the iteration matching the active operation.
  always_comb begin
    step_next = {1'b0, div_rem, div_quo};
    if (state_q == S_MULT) step_next = booth_next;
  end

  // Final result and exception cause from the finished accumulator.
  always_comb begin
    fin_result = acc_q[WORD:1];
    fin_cause  = EXC_NONE;
    if (state_q == S_MULT) begin
      if (acc_q[2*WORD:WORD+1] != {WORD{acc_q[WORD]}}) fin_cause = EXC_MULT_OVF;
    end else if (dbz_q) begin
      fin_result = '0;
      fin_cause  = EXC_DIV_ZERO;
    end else begin
      fin_result = neg_q ? negate(acc_q[WORD-1:0]) : acc_q[WORD-1:0];
      if (acc_q[WORD-1] && !neg_q) fin_cause = EXC_DIV_OVF;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a start always wins; otherwise run, complete, return to idle.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ctrl_MULT ? S_MULT : S_DIV;
    end else begin
      unique case (state_q)
        S_IDLE:         state_d = S_IDLE;
        S_MULT, S_DIV:  if (fin_q) state_d = S_DONE;
        S_DONE:         state_d = S_IDLE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, one iteration per cycle, result commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q        <= '0;
      fin_q          <= 1'b0;
      acc_q          <= '0;
      opb_q          <= '0;
      neg_q          <= 1'b0;
      dbz_q          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      count_q <= '0;
      fin_q   <= 1'b0;
      if (ctrl_MULT) begin
        acc_q <= {{WORD{1'b0}}, data_operandB, 1'b0};
        opb_q <= data_operandA;
        neg_q <= 1'b0;
        dbz_q <= 1'b0;
      end else begin
        acc_q <= {{(WORD+1){1'b0}}, magnitude(data_operandA)};
        opb_q <= magnitude(data_operandB);
        neg_q <= data_operandA[WORD-1] ^ data_operandB[WORD-1];
        dbz_q <= (data_operandB == '0);
      end
    end else if (busy && !fin_q) begin
      acc_q   <= step_next;
      count_q <= count_q + CNT_ONE;
      if (count_q == LAST_ITER) fin_q <= 1'b1;
    end else if (busy && fin_q) begin
      data_result    <= fin_result;
      data_exception <= (fin_cause != EXC_NONE);
      fin_q          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Bench for mult_div: directed corner cases, restart/abort and reset
// scenarios, then randomized operations against an arithmetic model.
module tb_mult_div;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [1:0]  dbg_state;

  mult_div dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {exception, result}
  int          due_q[$];   // edge number after which RDY must be seen
  logic [32:0] last_exp = '0;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Reference model: plain signed arithmetic.
  function automatic logic [32:0] model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    int          ia, ib, q;
    logic [63:0] pv;
    logic [31:0] qv;
    ia = $signed(a);
    ib = $signed(b);
    if (is_mult) begin
      p  = longint'(ia) * longint'(ib);
      pv = p;
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), pv[31:0]};
    end
    if (ib == 0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q  = ia / ib;
    qv = q;
    return {1'b0, qv};
  endfunction

  // Monitor: every RDY pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    logic [32:0] e;
    int          d;
    if (reset && data_resultRDY) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rdy at cycle %0d: got result %h exc %b expected no pulse",
                 cyc, data_result, data_exception);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("result", {31'b0, data_exception, data_result}, {31'b0, e});
        check("latency", 64'(cyc), 64'(d));
        last_exp = e;
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = cyc + 1;
    // Any op that would complete at or after this start's edge is aborted.
    while (due_q.size() > 0 && due_q[$] >= n) begin
      void'(due_q.pop_back());
      void'(exp_q.pop_back());
    end
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    if (m || d) begin
      exp_q.push_back(model(m, a, b));
      due_q.push_back(n + 33);
    end
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 80) begin
      @(posedge clock); #1;
      data_operandA = $urandom;
      data_operandB = $urandom;
      k++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL timeout at cycle %0d: got %0d pending results expected 0", cyc, exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
    repeat (3) begin
      @(posedge clock); #1;
    end
    check("hold", {31'b0, data_exception, data_result}, {31'b0, last_exp});
  endtask

  task automatic check_cleared(input string tag);
    @(negedge clock);
    check({tag, "_result"}, 64'(data_result), 64'h0);
    check({tag, "_exc"},    64'(data_exception), 64'h0);
    check({tag, "_rdy"},    64'(data_resultRDY), 64'h0);
    check({tag, "_state"},  64'(dbg_state), 64'h0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners[6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    check_cleared("reset");

    // Start on the very first edge after reset release.
    @(posedge clock); #1;
    reset = 1'b1;
    issue(1, 0, 32'd7, 32'hFFFF_FFFD);          // 7 x -3
    wait_done();
    issue(1, 0, 32'h0001_0000, 32'h0001_0000);  // product overflows
    wait_done();
    issue(0, 1, 32'hFFFF_FFF9, 32'd2);          // -7 / 2
    wait_done();
    issue(0, 1, 32'd5, 32'd0);                  // divide by zero
    wait_done();
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);  // quotient overflow
    wait_done();
    issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF);  // min x -1 overflows
    wait_done();
    issue(0, 1, 32'h8000_0000, 32'd1);          // min / 1 is representable
    wait_done();
    issue(1, 1, 32'd6, 32'd7);                  // both pulses: multiply wins
    wait_done();

    // Restart mid-multiply with a divide.
    issue(1, 0, 32'd3, 32'd4);
    repeat (9) begin @(posedge clock); #1; end
    issue(0, 1, 32'd100, 32'd7);
    wait_done();

    // Restart on the exact edge the first op would complete: no pulse for it.
    issue(1, 0, 32'd11, 32'd13);
    repeat (32) begin @(posedge clock); #1; end
    issue(0, 1, 32'hFFFF_FF9C, 32'd9);
    wait_done();

    // Start while in DONE: the finished op still reports, then the new one.
    issue(0, 1, 32'd1000, 32'hFFFF_FFFD);
    repeat (33) begin @(posedge clock); #1; end
    issue(1, 0, 32'h1234_5678, 32'd16);
    wait_done();

    // Randomized operations with operands scrambled while busy.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) issue(1, 0, pick(), pick());
      else                           issue(0, 1, pick(), pick());
      wait_done();
    end

    // Reset mid-operation: outputs clear and no pulse afterwards.
    issue(1, 0, 32'd5, 32'd9);
    repeat (15) begin @(posedge clock); #1; end
    reset = 1'b0;
    exp_q.delete();
    due_q.delete();
    check_cleared("midreset");
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (40) begin @(posedge clock); #1; end
    check("post_reset_result", {31'b0, data_exception, data_result}, 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
